// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg -- shared state encodings, funct3 size codes and request-check helpers.
package dmem_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int F3_UNSIGNED_BIT = 2;

  function automatic logic size_illegal(input logic [1:0] sz);
    return sz == 2'b11;
  endfunction

  function automatic logic store_unsigned(input logic wr, input logic [2:0] f3);
    return wr && f3[F3_UNSIGNED_BIT];
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SIZE_H) && lo[0]) || ((sz == SIZE_W) && (lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/RamSp.sv
`default_nettype none
// RamSp -- word-wide single-port RAM, synchronous read-first, no byte enables.
module RamSp #(
  parameter int    ADDR_BITS  = 9,
  parameter int    DATA_WIDTH = 32,
  parameter string DATA_FILE  = ""
) (
  input  logic                  Clk,
  input  logic [ADDR_BITS-1:0]  Addr,
  input  logic                  WrEn,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] RdData
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem_q[Addr] <= WrData;
    end
    RdData <= mem_q[Addr];
  end

  // Preload from DATA_FILE is applied by the implementation flow; this model starts blank.
  if (DATA_FILE == "") begin : g_blank_init
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// dmem_lane_unit -- combinational load lane extract/extend and sub-word store merge.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  shift;
  logic [15:0] lane;
  logic        sext;

  always_comb begin
    shift     = {addr_lo_i, 3'b000};
    lane      = 16'(rd_word_i >> shift);
    sext      = ~size_i[F3_UNSIGNED_BIT];
    ld_data_o = rd_word_i;
    st_word_o = st_data_i;
    case (size_i[1:0])
      SIZE_B: begin
        ld_data_o = {{24{sext & lane[7]}}, lane[7:0]};
        st_word_o = (rd_word_i & ~(32'h0000_00FF << shift)) | ({24'd0, st_data_i[7:0]} << shift);
      end
      SIZE_H: begin
        ld_data_o = {{16{sext & lane[15]}}, lane};
        st_word_o = (rd_word_i & ~(32'h0000_FFFF << shift)) | ({16'd0, st_data_i[15:0]} << shift);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder -- load/store responder over a single-port word RAM (RMW for sub-word stores).
// Optional sticky first-error capture ports under `DMEM_ERR_CAPTURE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 32,
  parameter int    DATA_WIDTH    = 32,
  parameter int    RAM_ADDR_BITS = 9,
  parameter int    WAIT_STATES   = 0,
  parameter string DATA_FILE     = "Data.hex"
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [2:0]            ReqSize,
  input  logic [DATA_WIDTH-1:0] ReqWrData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspRdData,
  output logic                  RspErr
`ifdef DMEM_ERR_CAPTURE_EN
  ,
  output logic                  ErrValid,
  output logic [ADDR_WIDTH-1:0] ErrAddr
`endif
);

  localparam int              CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [RAM_ADDR_BITS+1:0] addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    req_err;
  state_t                  req_first, cap_first;
  logic [DATA_WIDTH-1:0]   ram_rdata, ld_word, st_word;

  always_comb begin
    req_err = size_illegal(ReqSize[1:0])
           || store_unsigned(ReqWrite, ReqSize)
           || misaligned(ReqSize[1:0], ReqAddr[1:0])
           || (ReqAddr[ADDR_WIDTH-1:RAM_ADDR_BITS+2] != '0);
    // Word stores skip the read; everything else reads first.
    req_first = (ReqWrite && (ReqSize[1:0] == SIZE_W)) ? ST_WR : ST_RD;
    cap_first = (write_q && (size_q[1:0] == SIZE_W)) ? ST_WR : ST_RD;
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr[RAM_ADDR_BITS+1:0];
          size_d  = ReqSize;
          wdata_d = ReqWrData;
          rdata_d = '0;
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          if (req_err) begin
            state_d = ST_RESP;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = req_first;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = cap_first;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        if (write_q) begin
          wdata_d = st_word;
          state_d = ST_WR;
        end else begin
          rdata_d = ld_word;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: begin
        if (RspReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ReqReady  = (state_q == ST_IDLE);
  assign RspValid  = (state_q == ST_RESP);
  assign RspRdData = rdata_q;
  assign RspErr    = err_q;

`ifdef DMEM_ERR_CAPTURE_EN
  logic                  err_valid_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if ((state_q == ST_IDLE) && ReqValid && req_err && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= ReqAddr;
    end
  end

  assign ErrValid = err_valid_q;
  assign ErrAddr  = err_addr_q;
`endif

  dmem_lane_unit u_lane (
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .rd_word_i (ram_rdata),
    .st_data_i (wdata_q),
    .ld_data_o (ld_word),
    .st_word_o (st_word)
  );

  // Write enable decoded from state only, so reset kills an in-flight store at once.
  RamSp #(
    .ADDR_BITS  (RAM_ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_FILE  (DATA_FILE)
  ) u_ram (
    .Clk    (Clk),
    .Addr   (addr_q[RAM_ADDR_BITS+1:2]),
    .WrEn   (state_q == ST_WR),
    .WrData (wdata_q),
    .RdData (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder -- directed bench with a byte-level memory model; unit 0 has WAIT_STATES=0, unit 1 has 2.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, req_valid, req_write, rsp_ready, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_data  [2];
`ifdef DMEM_ERR_CAPTURE_EN
  logic [1:0]  err_valid;
  logic [31:0] err_addr [2];
`endif

  int n_pass = 0;
  int n_total = 0;

  dmem_responder #(.WAIT_STATES(0), .DATA_FILE("")) u_dut0 (
    .Clk(clk), .ResetN(rst_n[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write[0]), .ReqAddr(req_addr[0]), .ReqSize(req_size[0]), .ReqWrData(req_wdata[0]),
    .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]), .RspRdData(rsp_data[0]), .RspErr(rsp_err[0])
`ifdef DMEM_ERR_CAPTURE_EN
    , .ErrValid(err_valid[0]), .ErrAddr(err_addr[0])
`endif
  );

  dmem_responder #(.WAIT_STATES(2), .DATA_FILE("")) u_dut2 (
    .Clk(clk), .ResetN(rst_n[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write[1]), .ReqAddr(req_addr[1]), .ReqSize(req_size[1]), .ReqWrData(req_wdata[1]),
    .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]), .RspRdData(rsp_data[1]), .RspErr(rsp_err[1])
`ifdef DMEM_ERR_CAPTURE_EN
    , .ErrValid(err_valid[1]), .ErrAddr(err_addr[1])
`endif
  );

  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got 0x%08h expected 0x%08h", u, nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mem [int];
  bit          busy [2];
  int          k [2];
  int          lat [2];
  logic        e_err [2];
  logic [31:0] e_data [2];
  bit          pw [2];
  int          pw_addr [2];
  int          pw_n [2];
  logic [31:0] pw_data [2];

  function automatic logic [7:0] rdb(input int u, input int a);
    if (mem.exists(u * 65536 + a)) return mem[u * 65536 + a];
    return 8'h00;
  endfunction

  task automatic model_accept(input int u);
    logic [31:0] a, v;
    logic [2:0]  s;
    int          n;
    bit          e;
    a = req_addr[u];
    s = req_size[u];
    n = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    e = (s[1:0] == 2'd3) || (req_write[u] && s[2]) || ((a % n) != 0) || (a >= 32'd2048);
    pw[u] = 1'b0;
    e_err[u] = e;
    e_data[u] = 32'h0;
    if (e) lat[u] = 1;
    else begin
      lat[u] = (u == 1) ? 2 : 0;
      if (req_write[u]) begin
        lat[u] += (n == 4) ? 2 : 4;
        pw[u] = 1'b1; pw_addr[u] = int'(a); pw_n[u] = n; pw_data[u] = req_wdata[u];
      end else begin
        lat[u] += 3;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v + (32'(rdb(u, int'(a) + i)) << (8 * i));
        if (n < 4 && !s[2] && v[8*n-1]) v = v - (32'd1 << (8 * n));
        e_data[u] = v;
      end
    end
  endtask

  // Compare process: checks every cycle against the model, then advances it.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n[u]) begin
        busy[u] = 1'b0;
        chk(u, "rst ReqReady", 32'(req_ready[u]), 32'd1);
        chk(u, "rst RspValid", 32'(rsp_valid[u]), 32'd0);
        chk(u, "rst RspRdData", rsp_data[u], 32'd0);
        chk(u, "rst RspErr", 32'(rsp_err[u]), 32'd0);
      end else begin
        chk(u, "model ReqReady", 32'(req_ready[u]), 32'(!busy[u]));
        chk(u, "model RspValid", 32'(rsp_valid[u]), 32'(busy[u] && k[u] >= lat[u]));
        if (busy[u] && k[u] >= lat[u]) begin
          chk(u, "model RspRdData", rsp_data[u], e_data[u]);
          chk(u, "model RspErr", 32'(rsp_err[u]), 32'(e_err[u]));
        end
        if (busy[u]) begin
          if (k[u] >= lat[u] && rsp_ready[u]) begin
            busy[u] = 1'b0;
            if (pw[u])
              for (int i = 0; i < pw_n[u]; i++)
                mem[u * 65536 + pw_addr[u] + i] = 8'(pw_data[u] >> (8 * i));
          end else k[u]++;
        end else if (req_valid[u]) begin
          model_accept(u);
          busy[u] = 1'b1;
          k[u] = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xact(input int u, input string nm, input bit w, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d,
                      input logic [31:0] exp_d, input bit exp_e, input int exp_lat);
    int cyc;
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_size[u] = s; req_wdata[u] = d;
    rsp_ready[u] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[u]) break;
    end
    @(posedge clk); #1 req_valid[u] = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[u]) break;
    end
    chk(u, {nm, " latency"}, 32'(cyc), 32'(exp_lat));
    chk(u, {nm, " data"}, rsp_data[u], exp_d);
    chk(u, {nm, " err"}, 32'(rsp_err[u]), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  logic [31:0] ea [5];
  logic [2:0]  es [5];
  logic        ew [5];
  int          cyc;

  initial begin
    rst_n = 2'b11; req_valid = '0; req_write = '0; rsp_ready = 2'b11;
    for (int u = 0; u < 2; u++) begin req_addr[u] = '0; req_size[u] = '0; req_wdata[u] = '0; end
    ea = '{32'h11, 32'h12, 32'h800, 32'h10, 32'h10};
    es = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    #2 rst_n = 2'b00;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk(u, "async rst ReqReady", 32'(req_ready[u]), 32'd1);
      chk(u, "async rst RspValid", 32'(rsp_valid[u]), 32'd0);
      chk(u, "async rst RspRdData", rsp_data[u], 32'd0);
      chk(u, "async rst RspErr", 32'(rsp_err[u]), 32'd0);
`ifdef DMEM_ERR_CAPTURE_EN
      chk(u, "rst ErrValid", 32'(err_valid[u]), 32'd0);
      chk(u, "rst ErrAddr", err_addr[u], 32'd0);
`endif
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 2'b11;

    xact(0, "SW 0x10",  1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 2);
    xact(0, "LW 0x10",  0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, 3);
    xact(0, "SB 0x13",  1, 32'h13, 3'b000, 32'h00000080, 32'h0, 0, 4);
    xact(0, "LW 0x10b", 0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0, 3);
    xact(0, "LB 0x13",  0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 0, 3);
    xact(0, "LBU 0x13", 0, 32'h13, 3'b100, 32'h0, 32'h00000080, 0, 3);
    xact(0, "SH 0x10",  1, 32'h10, 3'b001, 32'hFFFF1234, 32'h0, 0, 4);
    xact(0, "LHU 0x10", 0, 32'h10, 3'b101, 32'h0, 32'h00001234, 0, 3);
    xact(0, "LH 0x12",  0, 32'h12, 3'b001, 32'h0, 32'hFFFF80AD, 0, 3);
    xact(0, "LBU 0x11", 0, 32'h11, 3'b100, 32'h0, 32'h00000012, 0, 3);

    for (int i = 0; i < 5; i++) begin
      xact(0, $sformatf("err case %0d", i), ew[i], ea[i], es[i], 32'hFFFFFFFF, 32'h0, 1, 1);
      xact(0, $sformatf("LW after err %0d", i), 0, 32'h10, 3'b010, 32'h0, 32'h80AD1234, 0, 3);
    end
`ifdef DMEM_ERR_CAPTURE_EN
    chk(0, "ErrValid sticky", 32'(err_valid[0]), 32'd1);
    chk(0, "ErrAddr first", err_addr[0], 32'h11);
`endif

    // Backpressure with a second request already pending.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 3'b010;
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[0]) break;
    end
    chk(0, "bp latency", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk(0, "bp RspValid held", 32'(rsp_valid[0]), 32'd1);
      chk(0, "bp ReqReady low", 32'(req_ready[0]), 32'd0);
      chk(0, "bp data stable", rsp_data[0], 32'h80AD1234);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(0, "bp ReqReady after handshake", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[0]) break;
    end
    chk(0, "bp second latency", 32'(cyc), 32'd3);
    chk(0, "bp second data", rsp_data[0], 32'h80AD1234);
    @(posedge clk); #1;

    // Two wait states, then reset during the read-modify-write of a byte store.
    xact(1, "WS2 SW 0x10", 1, 32'h10, 3'b010, 32'hCAFEF00D, 32'h0, 0, 4);
    xact(1, "WS2 LW 0x10", 0, 32'h10, 3'b010, 32'h0, 32'hCAFEF00D, 0, 5);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h10; req_size[1] = 3'b000;
    req_wdata[1] = 32'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[1]) break;
    end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    chk(1, "abort ReqReady", 32'(req_ready[1]), 32'd1);
    chk(1, "abort RspValid", 32'(rsp_valid[1]), 32'd0);
    chk(1, "abort RspErr", 32'(rsp_err[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n[1] = 1'b1;
    xact(1, "WS2 LW after abort", 0, 32'h10, 3'b010, 32'h0, 32'hCAFEF00D, 0, 5);
`ifdef DMEM_ERR_CAPTURE_EN
    chk(1, "ErrValid none", 32'(err_valid[1]), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
